// File: rtl/tb_ctrl_periph.sv
// Testbench control peripheral: decodes bus stores into stdout characters,
// pass/fail/exit pulses, and provides a cycle counter with a compare timer.
module tb_ctrl_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        sel_o,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        irq_timer_o
);

  typedef enum logic [5:0] {
    REG_STDOUT = 6'h00,
    REG_EXIT   = 6'h04,
    REG_STATUS = 6'h08,
    REG_CYCLE  = 6'h0C,
    REG_CMP    = 6'h10,
    REG_CTRL   = 6'h14
  } reg_off_e;

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [5:0]    off;
  logic          stdout_wr;
  logic          fifo_full;
  logic          acc;
  logic          wr_acc;
  logic          push;
  logic          pop;
  logic [31:0]   rd_next;
  logic [31:0]   cycle_q;
  logic [31:0]   cmp_q;
  logic          en_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          unused_be;

  assign unused_be = ^be_i[3:1];

  assign off       = addr_i[5:0];
  assign sel_o     = (addr_i[31:6] == BASE_ADDR[31:6]);
  assign stdout_wr = req_i & we_i & (off == REG_STDOUT);
  // Stall decision uses the registered count, so a pop in the same cycle
  // cannot release a stalled write until the following cycle.
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign gnt_o     = req_i & sel_o & ~(stdout_wr & fifo_full);
  assign acc       = req_i & gnt_o;
  assign wr_acc    = acc & we_i;
  assign push      = wr_acc & (off == REG_STDOUT) & be_i[0];

  assign char_valid_o = (count != '0);
  assign char_o       = char_valid_o ? mem[rd_ptr] : '0;
  assign pop          = char_valid_o & char_ready_i;

  // Read data mux for the granted address; writes and write-only regs read 0.
  always_comb begin
    rd_next = '0;
    if (!we_i) begin
      case (off)
        REG_CYCLE: rd_next = cycle_q;
        REG_CMP:   rd_next = cmp_q;
        REG_CTRL:  rd_next = {30'b0, irq_timer_o, en_q};
        default:   rd_next = '0;
      endcase
    end
  end

  // FIFO storage, no reset needed since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata_i[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Bus response, status pulses and exit value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_o       <= 1'b0;
      rdata_o        <= '0;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
    end else begin
      rvalid_o       <= acc;
      rdata_o        <= acc ? rd_next : '0;
      tests_passed_o <= wr_acc & (off == REG_STATUS) & (wdata_i == PASS_MAGIC);
      tests_failed_o <= wr_acc & (off == REG_STATUS) & (wdata_i == 32'd1);
      exit_valid_o   <= wr_acc & (off == REG_EXIT);
      if (wr_acc && off == REG_EXIT) exit_value_o <= wdata_i;
    end
  end

  // Cycle counter, compare timer registers and sticky interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q     <= '0;
      cmp_q       <= '0;
      en_q        <= 1'b0;
      irq_timer_o <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (wr_acc && off == REG_CMP)  cmp_q <= wdata_i;
      if (wr_acc && off == REG_CTRL) en_q  <= wdata_i[0];
      if (en_q && cycle_q == cmp_q)
        irq_timer_o <= 1'b1;
      else if (wr_acc && off == REG_CTRL && wdata_i[1])
        irq_timer_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tb_ctrl_periph.sv
// Self-checking bench for tb_ctrl_periph: randomized bus traffic checked
// against a reference model (cycle count, expected char queue, registers).
module tb_tb_ctrl_periph;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] addr_i = BASE;
  logic [31:0] wdata_i = '0;
  logic        char_ready_i = 1'b0;
  logic        sel_o, gnt_o, rvalid_o, char_valid_o;
  logic [31:0] rdata_o, exit_value_o;
  logic [7:0]  char_o;
  logic        tests_passed_o, tests_failed_o, exit_valid_o, irq_timer_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc_m;
  logic [7:0]  exp_q [$];

  tb_ctrl_periph #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(16),
    .PASS_MAGIC(MAGIC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .we_i          (we_i),
    .be_i          (be_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .sel_o         (sel_o),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .char_valid_o  (char_valid_o),
    .char_o        (char_o),
    .char_ready_i  (char_ready_i),
    .tests_passed_o(tests_passed_o),
    .tests_failed_o(tests_failed_o),
    .exit_valid_o  (exit_valid_o),
    .exit_value_o  (exit_value_o),
    .irq_timer_o   (irq_timer_o)
  );

  always #5 clk = ~clk;

  // Reference cycle count: clock edges seen since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_m <= '0;
    else        cyc_m <= cyc_m + 32'd1;
  end

  // Character sink: every handshake must deliver the oldest expected char.
  always @(negedge clk) begin
    if (rst_n && char_valid_o && char_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL char_unexpected got %02h exp none", char_o);
      end else if (char_o !== exp_q[0]) begin
        errors++;
        $display("FAIL char_order got %02h exp %02h", char_o, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // One bus transfer; returns grant status, wait cycles and the response.
  task automatic xfer(input logic w, input logic [5:0] off, input logic [31:0] wd,
                      input logic [3:0] be, output logic ok, output int unsigned nw,
                      output logic rv, output logic [31:0] rd, output logic [31:0] gc);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = w; addr_i = {BASE[31:6], off}; wdata_i = wd; be_i = be;
    nw = 0;
    @(negedge clk);
    while (!gnt_o && nw < 300) begin
      @(negedge clk);
      nw++;
    end
    ok = gnt_o;
    gc = cyc_m;
    if (ok && w && off == 6'h00 && be[0]) exp_q.push_back(wd[7:0]);
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    rv = rvalid_o;
    rd = rdata_o;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = BASE;
    wdata_i = '0; char_ready_i = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({rvalid_o, char_valid_o, tests_passed_o, tests_failed_o, exit_valid_o, irq_timer_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000",
               {rvalid_o, char_valid_o, tests_passed_o, tests_failed_o, exit_valid_o, irq_timer_o});
    end
    checks++;
    if (rdata_o !== 32'h0 || exit_value_o !== 32'h0 || char_o !== 8'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h exp 0", rdata_o, exit_value_o, char_o);
    end
    req_i = 1'b1; addr_i = BASE + 32'h10; #1;
    checks++;
    if (sel_o !== 1'b1 || gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_sel_in got %b%b exp 11", sel_o, gnt_o);
    end
    addr_i = BASE + 32'h40; #1;
    checks++;
    if (sel_o !== 1'b0 || gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_sel_out got %b%b exp 00", sel_o, gnt_o);
    end
    req_i = 1'b0; addr_i = BASE;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stdout_basic();
    logic ok, rv; int unsigned nw; logic [31:0] rd, gc;
    char_ready_i = 1'b1;
    xfer(1'b1, 6'h00, 32'h41, 4'h1, ok, nw, rv, rd, gc);
    checks++;
    if (!ok || nw != 0 || rv !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL stdout_resp got ok=%b nw=%0d rv=%b rd=%h exp 1 0 1 0", ok, nw, rv, rd);
    end
    checks++;
    if (char_valid_o !== 1'b1 || char_o !== 8'h41) begin
      errors++;
      $display("FAIL stdout_char got %b/%h exp 1/41", char_valid_o, char_o);
    end
    @(negedge clk);
    checks++;
    if (rvalid_o !== 1'b0 || char_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stdout_after got rv=%b cv=%b exp 0 0", rvalid_o, char_valid_o);
    end
  endtask

  task automatic test_fifo_full();
    logic ok, rv; int unsigned nw; logic [31:0] rd, gc;
    char_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 6'h00, 32'h30 + 32'(i), 4'h1, ok, nw, rv, rd, gc);
      checks++;
      if (!ok || nw != 0 || rv !== 1'b1) begin
        errors++;
        $display("FAIL fill_%0d got ok=%b nw=%0d rv=%b exp 1 0 1", i, ok, nw, rv);
      end
    end
    checks++;
    if (char_valid_o !== 1'b1 || char_o !== 8'h30) begin
      errors++;
      $display("FAIL full_head got %b/%h exp 1/30", char_valid_o, char_o);
    end
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b1; addr_i = BASE; wdata_i = 32'h40; be_i = 4'h1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (gnt_o !== 1'b0) begin
        errors++;
        $display("FAIL full_stall got %b exp 0", gnt_o);
      end
    end
    @(posedge clk); #1;
    char_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_pop_same_cycle got %b exp 0", gnt_o);
    end
    @(negedge clk);
    checks++;
    if (gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL unstall got %b exp 1", gnt_o);
    end else begin
      exp_q.push_back(8'h40);
    end
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL unstall_resp got %b exp 1", rvalid_o);
    end
    for (int k = 0; k < 100 && (exp_q.size() != 0 || char_valid_o); k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || char_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL full_drain got left=%0d cv=%b exp 0 0", exp_q.size(), char_valid_o);
    end
  endtask

  task automatic test_random_stdout();
    logic ok, rv; int unsigned nw; logic [31:0] rd, gc;
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          xfer(1'b1, 6'h00, $urandom, 4'($urandom), ok, nw, rv, rd, gc);
          checks++;
          if (!ok || rv !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL rnd_stdout_%0d got ok=%b rv=%b rd=%h exp 1 1 0", i, ok, rv, rd);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          char_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    char_ready_i = 1'b1;
    for (int k = 0; k < 100 && (exp_q.size() != 0 || char_valid_o); k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || char_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain got left=%0d cv=%b exp 0 0", exp_q.size(), char_valid_o);
    end
  endtask

  task automatic test_status();
    logic ok, rv; int unsigned nw; logic [31:0] rd, gc, v;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: v = MAGIC;
        1: v = 32'd1;
        2: v = 32'd5;
        3: v = 32'd0;
        4: v = $urandom;
        default: v = MAGIC;
      endcase
      xfer(1'b1, 6'h08, v, 4'($urandom), ok, nw, rv, rd, gc);
      checks++;
      if (!ok || rv !== 1'b1 || tests_passed_o !== (v == MAGIC) || tests_failed_o !== (v == 32'd1)) begin
        errors++;
        $display("FAIL status_%0d got ok=%b rv=%b p=%b f=%b exp 1 1 %b %b",
                 i, ok, rv, tests_passed_o, tests_failed_o, v == MAGIC, v == 32'd1);
      end
      @(negedge clk);
      checks++;
      if (tests_passed_o !== 1'b0 || tests_failed_o !== 1'b0) begin
        errors++;
        $display("FAIL status_pulse_len_%0d got %b%b exp 00", i, tests_passed_o, tests_failed_o);
      end
    end
  endtask

  task automatic test_exit();
    logic ok, rv; int unsigned nw; logic [31:0] rd, gc, v;
    for (int i = 0; i < 3; i++) begin
      v = (i == 0) ? 32'd7 : $urandom;
      xfer(1'b1, 6'h04, v, 4'h0, ok, nw, rv, rd, gc);
      checks++;
      if (!ok || exit_valid_o !== 1'b1 || exit_value_o !== v) begin
        errors++;
        $display("FAIL exit_%0d got ok=%b ev=%b val=%h exp 1 1 %h", i, ok, exit_valid_o, exit_value_o, v);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (exit_valid_o !== 1'b0 || exit_value_o !== v) begin
        errors++;
        $display("FAIL exit_hold_%0d got ev=%b val=%h exp 0 %h", i, exit_valid_o, exit_value_o, v);
      end
    end
  endtask

  task automatic test_cycle();
    logic ok, rv; int unsigned nw; logic [31:0] rd1, rd2, gc1, gc2;
    xfer(1'b0, 6'h0C, 32'h0, 4'h0, ok, nw, rv, rd1, gc1);
    checks++;
    if (!ok || rv !== 1'b1 || rd1 !== gc1) begin
      errors++;
      $display("FAIL cycle_read got ok=%b rv=%b rd=%h exp 1 1 %h", ok, rv, rd1, gc1);
    end
    repeat (8) @(negedge clk);
    xfer(1'b0, 6'h0C, 32'h0, 4'h0, ok, nw, rv, rd2, gc2);
    checks++;
    if (rd2 - rd1 !== 32'd10 || rd2 !== gc2) begin
      errors++;
      $display("FAIL cycle_delta got %h exp %h", rd2 - rd1, 32'd10);
    end
  endtask

  task automatic test_unmapped();
    logic ok, rv; int unsigned nw; logic [31:0] rd, gc, c;
    logic [5:0] off;
    c = $urandom;
    char_ready_i = 1'b1;
    xfer(1'b1, 6'h10, c, 4'h0, ok, nw, rv, rd, gc);
    off = 6'h18 + 6'(4 * $urandom_range(0, 9));
    xfer(1'b1, off, $urandom, 4'hF, ok, nw, rv, rd, gc);
    checks++;
    if (!ok || rv !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_wr got ok=%b rv=%b exp 1 1", ok, rv);
    end
    xfer(1'b0, off, 32'h0, 4'h0, ok, nw, rv, rd, gc);
    checks++;
    if (!ok || rv !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_rd got ok=%b rv=%b rd=%h exp 1 1 0", ok, rv, rd);
    end
    xfer(1'b0, 6'h3C, 32'h0, 4'h0, ok, nw, rv, rd, gc);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL rd_3c got %h exp 0", rd);
    end
    xfer(1'b0, 6'h10, 32'h0, 4'h0, ok, nw, rv, rd, gc);
    checks++;
    if (rd !== c) begin
      errors++;
      $display("FAIL cmp_readback got %h exp %h", rd, c);
    end
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 6'(4 * i), 32'h0, 4'h0, ok, nw, rv, rd, gc);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL wo_read_%0d got %h exp 0", i, rd);
      end
    end
    xfer(1'b1, 6'h00, 32'h5A, 4'hE, ok, nw, rv, rd, gc);
    @(negedge clk);
    checks++;
    if (char_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stdout_be0 got %b exp 0", char_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic ok, rv; int unsigned nw; logic [31:0] rd, gc;
    logic [31:0] q [$];
    logic [31:0] m_cmp, wd, e;
    int unsigned op;
    logic [5:0] off;
    logic w;
    xfer(1'b1, 6'h14, 32'h2, 4'h0, ok, nw, rv, rd, gc);
    m_cmp = 32'hA5A5_0001;
    xfer(1'b1, 6'h10, m_cmp, 4'h0, ok, nw, rv, rd, gc);
    op = 0;
    wd = '0;
    for (int i = 0; i <= 30; i++) begin
      @(posedge clk); #1;
      if (i < 30) begin
        op = $urandom_range(0, 5);
        wd = $urandom;
        case (op)
          0: begin w = 1'b0; off = 6'h10; end
          1: begin w = 1'b1; off = 6'h10; end
          2: begin w = 1'b0; off = 6'h0C; end
          3: begin w = 1'b0; off = 6'h14; end
          4: begin w = 1'b0; off = 6'h20; end
          default: begin w = 1'b0; off = 6'h04; end
        endcase
        req_i = 1'b1; we_i = w; addr_i = {BASE[31:6], off}; wdata_i = wd; be_i = 4'hF;
      end else begin
        req_i = 1'b0; we_i = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        e = q.pop_front();
        checks++;
        if (rvalid_o !== 1'b1 || rdata_o !== e) begin
          errors++;
          $display("FAIL b2b_resp_%0d got rv=%b rd=%h exp 1 %h", i, rvalid_o, rdata_o, e);
        end
      end
      if (i < 30) begin
        checks++;
        if (gnt_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gnt_%0d got %b exp 1", i, gnt_o);
        end
        case (op)
          0: e = m_cmp;
          1: begin e = '0; m_cmp = wd; end
          2: e = cyc_m;
          default: e = '0;
        endcase
        q.push_back(e);
      end
    end
    @(negedge clk);
    checks++;
    if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL b2b_idle got rv=%b rd=%h exp 0 0", rvalid_o, rdata_o);
    end
  endtask

  task automatic test_timer();
    logic ok, rv; int unsigned nw; logic [31:0] rd, gc, x;
    test_reset();
    xfer(1'b1, 6'h10, 32'd100, 4'h0, ok, nw, rv, rd, gc);
    xfer(1'b1, 6'h14, 32'd1, 4'h0, ok, nw, rv, rd, gc);
    for (int k = 0; k < 300 && cyc_m != 32'd100; k++) @(negedge clk);
    checks++;
    if (cyc_m != 32'd100 || irq_timer_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_before got cyc=%0d irq=%b exp 100 0", cyc_m, irq_timer_o);
    end
    @(negedge clk);
    checks++;
    if (irq_timer_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise got %b exp 1", irq_timer_o);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (irq_timer_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_sticky got %b exp 1", irq_timer_o);
    end
    xfer(1'b1, 6'h14, 32'h3, 4'h0, ok, nw, rv, rd, gc);
    checks++;
    if (irq_timer_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear got %b exp 0", irq_timer_o);
    end
    xfer(1'b0, 6'h14, 32'h0, 4'h0, ok, nw, rv, rd, gc);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL ctrl_read got %h exp 1", rd);
    end
    x = cyc_m + 32'd30;
    xfer(1'b1, 6'h10, x, 4'h0, ok, nw, rv, rd, gc);
    for (int k = 0; k < 300 && cyc_m != x - 32'd1; k++) @(negedge clk);
    xfer(1'b1, 6'h14, 32'h3, 4'h0, ok, nw, rv, rd, gc);
    checks++;
    if (irq_timer_o !== 1'b1 || gc !== x) begin
      errors++;
      $display("FAIL irq_set_wins got irq=%b at=%0d exp 1 at %0d", irq_timer_o, gc, x);
    end
    xfer(1'b1, 6'h14, 32'h2, 4'h0, ok, nw, rv, rd, gc);
    xfer(1'b1, 6'h10, cyc_m + 32'd5, 4'h0, ok, nw, rv, rd, gc);
    repeat (15) @(negedge clk);
    checks++;
    if (irq_timer_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_disabled got %b exp 0", irq_timer_o);
    end
  endtask

  task automatic test_reset_mid();
    logic ok, rv; int unsigned nw; logic [31:0] rd, gc;
    char_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) xfer(1'b1, 6'h00, $urandom, 4'h1, ok, nw, rv, rd, gc);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b1; addr_i = BASE + 32'h4; wdata_i = 32'd9; be_i = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({rvalid_o, exit_valid_o, char_valid_o} !== 3'b0 || exit_value_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got %b val=%h exp 000 0", {rvalid_o, exit_valid_o, char_valid_o}, exit_value_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (char_valid_o !== 1'b0 || rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after got cv=%b rv=%b exp 0 0", char_valid_o, rvalid_o);
    end
  endtask

  initial begin
    test_reset();
    test_stdout_basic();
    test_fifo_full();
    test_random_stdout();
    test_status();
    test_exit();
    test_cycle();
    test_unmapped();
    test_back_to_back();
    test_timer();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tb_ctrl_periph.md
# tb_ctrl_periph

Memory-mapped testbench control peripheral on the core's data bus inside the TB subsystem. It decodes core stores into stdout characters, test pass/fail and exit events, and provides a free-running cycle counter and a compare timer interrupt. The single-cycle status pulses drive the top-level pass/fail/exit checks. The buffered stdout stream drains to a character sink through a valid/ready handshake.

## Interface
Parameters:
- BASE_ADDR, 32'h1000_0000, base of the 64-byte register window (bits [31:6] compared).
- FIFO_DEPTH, 16, stdout buffer entries; power of two, ≥2.
- PASS_MAGIC, 32'd123456789, TEST_STATUS write value meaning pass.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  1  bus request.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- sel_o  out  1  combinational; addr_i lies within the window.
- gnt_o  out  1  grant, combinational.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- char_valid_o  out  1  stdout character available.
- char_o  out  8  stdout character.
- char_ready_i  in  1  sink accepts character.
- tests_passed_o  out  1  one-cycle pulse.
- tests_failed_o  out  1  one-cycle pulse.
- exit_valid_o  out  1  one-cycle pulse.
- exit_value_o  out  32  value held from the last EXIT write.
- irq_timer_o  out  1  sticky timer interrupt.

## Operation
- Register offsets (addr_i[5:0]):
  - 0x00 STDOUT: write only; wdata[7:0] is pushed to the FIFO when be_i[0]=1.
  - 0x04 EXIT: write; exit_value_o <= wdata, exit_valid_o pulses.
  - 0x08 TEST_STATUS: write; PASS_MAGIC pulses tests_passed_o, 1 pulses tests_failed_o, other values are ignored.
  - 0x0C CYCLE: read only.
  - 0x10 TIMER_CMP: read/write.
  - 0x14 TIMER_CTRL: bit0 enable (read/write); writing 1 to bit1 clears irq; reads return {30'b0, irq, en}.
- Unmapped offsets: granted; writes ignored; reads return 0. be_i is ignored except at STDOUT. Reads of write-only registers return 0.
- gnt_o = req_i & sel_o. Exception: a STDOUT write while the FIFO is full (registered count) gets gnt_o=0 and the request is stalled.
- CYCLE: 32-bit counter, +1 every clk after reset, wraps 0xFFFF_FFFF→0. A read returns the value in the grant cycle.
- Timer: irq sets when en=1 and CYCLE==CMP. Set has priority over a clear in the same cycle.
- FIFO: char_valid_o = not empty, char_o = head. A pop occurs when valid & ready. Simultaneous push and pop keeps the count unchanged. A pop from a full FIFO does not unstall a write in that same cycle.

## Timing
- Reset values:
  - gnt_o and sel_o follow inputs.
  - All other outputs are 0; FIFO empty; CYCLE=0; CMP=0; CTRL=0.
- Accepted transfer (req&gnt) in cycle N:
  - rvalid_o=1 in N+1 for exactly one cycle, reads and writes alike.
  - rdata_o is valid in N+1 and 0 otherwise.
- Register writes take effect at the N→N+1 edge. Status pulses and exit_value_o update are visible in N+1; pulses last one cycle.
- A STDOUT push in cycle N gives char_valid_o=1 in N+1 at the earliest. FIFO order is preserved.
- Back-to-back transfers every cycle are supported; there is one response per grant with no reordering.
- Asynchronous reset mid-transfer: pending rvalid is dropped, FIFO is flushed, pulses are cleared.

## Test plan
- Reset, then a write of 0x41 to BASE+0x00 with ready=1 → rvalid 1 cycle after grant; char_valid_o=1, char_o=0x41 one cycle after grant, then low.
- char_ready_i=0 with 17 STDOUT writes of 0x30..0x40 → first 16 granted. The 17th stalls with gnt_o=0 until a pop frees a slot; drain order is 0x30..0x40.
- Write 123456789 to 0x08 → tests_passed_o high exactly one cycle. Write 1 → tests_failed_o. Write 5 → no pulse.
- Write 7 to 0x04 → exit_valid_o one-cycle pulse, exit_value_o=7 held.
- CMP=100, CTRL=1 → irq_timer_o rises the cycle after CYCLE reaches 100 and stays high. Writing CTRL=0x3 clears it; a clear coinciding with a match keeps it set.
- Read 0x0C twice, 10 cycles apart → values differ by 10. Read 0x3C → rdata_o=0.
